// File: rtl/ecc_apb_if.sv
// APB3 bus bundle for the ECC controller register bank.
// Valid/ready: a transfer is valid when PSEL and PENABLE are both high; it
// completes on the rising edge where PREADY is also high. The master holds
// PADDR/PWRITE/PWDATA stable until that edge.
interface ecc_apb_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/ecc_apb_ctrl.sv
// APB register bank and sequencer for the ECC encoder/decoder core.
// Holds operands, starts the core, waits for its result (with a watchdog),
// and stores results in a small queue read back through RESULT.
module ecc_apb_ctrl #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int RES_DEPTH       = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  ecc_apb_if.slave              apb,
  output logic                  core_start,
  output logic [1:0]            core_mode,
  output logic [DATA_WIDTH-1:0] core_data_in,
  output logic [DATA_WIDTH-1:0] core_noise,
  output logic [1:0]            core_cw_width,
  input  logic                  core_done,
  input  logic [DATA_WIDTH-1:0] core_data_out,
  input  logic [1:0]            core_nof,
  output logic                  operation_done,
  output logic                  irq,
  output logic [1:0]            fsm_state
);

  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int ENT_W = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_PUSH  = 2'd3
  } state_t;

  state_t               state;
  logic [TMO_W-1:0]     wait_cnt;

  logic [1:0]           mode_r;
  logic                 irq_en_r;
  logic [AMBA_WORD-1:0] data_in_r;
  logic [AMBA_WORD-1:0] cw_r;
  logic [AMBA_WORD-1:0] noise_r;
  logic                 rej_r;
  logic                 tmo_r;
  logic                 irq_r;

  logic [ENT_W-1:0]     mem [RES_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  logic [2:0]           offset;
  logic                 access;
  logic                 stall;
  logic                 xfer;
  logic                 wr;
  logic                 rd;
  logic                 empty;
  logic                 full;
  logic                 start_req;
  logic                 push;
  logic                 pop;
  logic                 tmo_set;
  logic [1:0]           nof_store;
  logic [ENT_W-1:0]     head;
  logic [AMBA_WORD-1:0] status;
  logic [AMBA_WORD-1:0] rdata;
  logic                 unused_addr;

  assign offset    = apb.PADDR[4:2];
  assign access    = apb.PSEL & apb.PENABLE;
  // Operand/control writes are held off while an operation is in flight.
  assign stall     = apb.PWRITE & (offset <= 3'd3) & (state != S_IDLE);
  assign xfer      = access & ~stall;
  assign wr        = xfer & apb.PWRITE;
  assign rd        = xfer & ~apb.PWRITE;
  assign apb.PREADY = xfer;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(RES_DEPTH));
  assign start_req = wr & (offset == 3'd0) & apb.PWDATA[2];
  assign push      = (state == S_WAIT) & core_done;
  assign pop       = rd & (offset == 3'd5) & ~empty;
  assign tmo_set   = (state == S_WAIT) & ~core_done & (wait_cnt == TMO_W'(TIMEOUT - 1));
  assign nof_store = (core_mode == 2'b00) ? 2'b00 : core_nof;
  assign head      = mem[rd_ptr];

  assign irq         = irq_r;
  assign fsm_state   = state;
  assign unused_addr = ^{apb.PADDR[AMBA_ADDR_WIDTH-1:5], apb.PADDR[1:0]};

  // STATUS word assembled from queue and sticky flags.
  always_comb begin
    status             = '0;
    status[0]          = (state != S_IDLE);
    status[1]          = empty;
    status[2]          = full;
    status[3]          = rej_r;
    status[4]          = tmo_r;
    status[9:8]        = empty ? 2'b00 : head[ENT_W-1 -: 2];
    status[16 +: CNT_W] = count;
  end

  // Read mux, driven only during a read access phase.
  always_comb begin
    rdata = '0;
    if (access && !apb.PWRITE) begin
      case (offset)
        3'd0: begin
          rdata[1:0] = mode_r;
          rdata[3]   = irq_en_r;
        end
        3'd1: rdata = data_in_r;
        3'd2: rdata = cw_r;
        3'd3: rdata = noise_r;
        3'd4: rdata = status;
        3'd5: if (!empty) rdata[DATA_WIDTH-1:0] = head[DATA_WIDTH-1:0];
        default: rdata = '0;
      endcase
    end
  end
  assign apb.PRDATA = rdata;

  // Register file, sticky reject/timeout flags and the interrupt line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r    <= '0;
      irq_en_r  <= 1'b0;
      data_in_r <= '0;
      cw_r      <= '0;
      noise_r   <= '0;
      rej_r     <= 1'b0;
      tmo_r     <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      if (wr) begin
        case (offset)
          3'd0: begin
            mode_r   <= apb.PWDATA[1:0];
            irq_en_r <= apb.PWDATA[3];
          end
          3'd1: data_in_r <= apb.PWDATA;
          3'd2: cw_r      <= apb.PWDATA;
          3'd3: noise_r   <= apb.PWDATA;
          default: ;
        endcase
      end
      if (start_req && full)
        rej_r <= 1'b1;
      else if (wr && offset == 3'd4 && apb.PWDATA[3])
        rej_r <= 1'b0;
      if (tmo_set)
        tmo_r <= 1'b1;
      else if (wr && offset == 3'd4 && apb.PWDATA[4])
        tmo_r <= 1'b0;
      irq_r <= irq_en_r & (~empty | rej_r | tmo_r);
    end
  end

  // Sequencer: start the core, wait for done or watchdog, then push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      core_start     <= 1'b0;
      core_mode      <= '0;
      core_data_in   <= '0;
      core_noise     <= '0;
      core_cw_width  <= '0;
      operation_done <= 1'b0;
    end else begin
      core_start     <= 1'b0;
      operation_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_req && !full) begin
            // Mode comes straight from the bus: the CTRL register updates on this same edge.
            state         <= S_ISSUE;
            core_start    <= 1'b1;
            core_mode     <= apb.PWDATA[1:0];
            core_data_in  <= data_in_r[DATA_WIDTH-1:0];
            core_noise    <= noise_r[DATA_WIDTH-1:0];
            core_cw_width <= cw_r[1:0];
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            state          <= S_PUSH;
            operation_done <= 1'b1;
          end else if (tmo_set) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_PUSH: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result queue: push from the core, pop on RESULT reads; both may happen together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RES_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {nof_store, core_data_out};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_apb_ctrl.sv
// Bench for ecc_apb_ctrl: APB driver tasks, a core responder, a queue-based
// reference model and a monitor that checks pulses and read data.
module tb_ecc_apb_ctrl;
  localparam int AW = 32;
  localparam int ADW = 20;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ecc_apb_if #(.ADDR_W(ADW), .DATA_W(AW)) bus ();

  logic          core_start;
  logic [1:0]    core_mode;
  logic [DW-1:0] core_data_in;
  logic [DW-1:0] core_noise;
  logic [1:0]    core_cw_width;
  logic          core_done;
  logic [DW-1:0] core_data_out;
  logic [1:0]    core_nof;
  logic          operation_done;
  logic          irq;
  logic [1:0]    fsm_state;

  ecc_apb_ctrl #(
    .AMBA_WORD(AW), .AMBA_ADDR_WIDTH(ADW), .DATA_WIDTH(DW),
    .RES_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .apb(bus.slave),
    .core_start(core_start), .core_mode(core_mode), .core_data_in(core_data_in),
    .core_noise(core_noise), .core_cw_width(core_cw_width), .core_done(core_done),
    .core_data_out(core_data_out), .core_nof(core_nof),
    .operation_done(operation_done), .irq(irq), .fsm_state(fsm_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues: {cycle, mode, data_in, noise, cw} per expected core_start.
  logic [99:0] exp_start_q[$];
  logic [31:0] exp_done_q[$];
  logic [31:0] exp_rd_q[$];
  string       rd_name_q[$];
  int          last_done_cyc = 0;

  // Reference model.
  logic [33:0] m_res[$];
  bit          m_rej, m_tmo, m_irq_en, m_pending;
  logic [1:0]  m_mode, m_issue_mode;
  logic [31:0] m_data, m_cw, m_noise;

  // Responder controls.
  int          r_delay = 0;
  bit          r_silent = 0;
  bit          r_fixed = 0;
  logic [31:0] r_val = '0;
  logic [1:0]  r_nof = '0;

  task automatic model_reset();
    m_res.delete();
    m_rej = 0; m_tmo = 0; m_irq_en = 0; m_pending = 0;
    m_mode = 0; m_issue_mode = 0; m_data = 0; m_cw = 0; m_noise = 0;
  endtask

  function automatic logic [31:0] status_exp();
    logic [31:0] s;
    s = '0;
    s[1] = (m_res.size() == 0);
    s[2] = (m_res.size() == DEPTH);
    s[3] = m_rej;
    s[4] = m_tmo;
    if (m_res.size() > 0) s[9:8] = m_res[0][33:32];
    s[18:16] = 3'(m_res.size());
    return s;
  endfunction

  // ---------------- APB driver ----------------
  task automatic apb_xfer(input logic [2:0] off, input bit write, input logic [31:0] wdata,
                          output int done_cyc, output int waits);
    @(posedge clk); #1;
    bus.PADDR = ADW'({off, 2'b00});
    bus.PWRITE = write; bus.PWDATA = wdata; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    waits = 0;
    while (1) begin
      @(negedge clk);
      if (bus.PREADY) break;
      waits++;
      if (waits > 300) begin
        check("apb_pready_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    done_cyc = cyc;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_write(input logic [2:0] off, input logic [31:0] wdata);
    int d, w;
    apb_xfer(off, 1'b1, wdata, d, w);
  endtask

  task automatic apb_read(input logic [2:0] off, input logic [31:0] exp, input string name);
    int d, w;
    exp_rd_q.push_back(exp);
    rd_name_q.push_back(name);
    apb_xfer(off, 1'b0, '0, d, w);
  endtask

  // ---------------- model-aware stimulus ----------------
  task automatic reg_write(input logic [2:0] off, input logic [31:0] v);
    apb_write(off, v);
    case (off)
      3'd1: m_data = v;
      3'd2: m_cw = v;
      3'd3: m_noise = v;
      3'd4: begin
        if (v[3]) m_rej = 0;
        if (v[4]) m_tmo = 0;
      end
      default: ;
    endcase
  endtask

  task automatic ctrl_write(input logic [1:0] mode, input bit start, input bit ien, output int done_cyc);
    int w;
    apb_xfer(3'd0, 1'b1, {28'd0, ien, start, mode}, done_cyc, w);
    m_mode = mode;
    m_irq_en = ien;
    if (start) begin
      if (m_res.size() >= DEPTH) m_rej = 1;
      else begin
        exp_start_q.push_back({32'(done_cyc), mode, m_data, m_noise, m_cw[1:0]});
        m_issue_mode = mode;
        m_pending = 1;
      end
    end
  endtask

  task automatic read_status(input string name);
    apb_read(3'd4, status_exp(), name);
  endtask

  task automatic read_result(input string name);
    logic [31:0] e;
    e = '0;
    if (m_res.size() > 0) begin
      e = m_res[0][31:0];
      void'(m_res.pop_front());
    end
    apb_read(3'd5, e, name);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && m_pending; i++) @(posedge clk);
    check("op_completes", m_pending, 0);
    m_pending = 0;
    repeat (3) @(posedge clk);
  endtask

  task automatic check_irq(input string name);
    @(negedge clk);
    check(name, irq, m_irq_en & ((m_res.size() > 0) | m_rej | m_tmo));
  endtask

  task automatic run_op(input logic [1:0] mode, input int delay);
    int d;
    r_delay = delay;
    ctrl_write(mode, 1'b1, m_irq_en, d);
    wait_idle();
  endtask

  // ---------------- core responder ----------------
  initial begin
    int          d;
    logic [31:0] v;
    logic [1:0]  n;
    core_done = 1'b0; core_data_out = '0; core_nof = '0;
    forever begin
      @(negedge clk);
      if (core_start && rst && !r_silent) begin
        d = (r_delay > 0) ? r_delay : $urandom_range(1, 10);
        v = r_fixed ? r_val : $urandom;
        n = r_fixed ? r_nof : 2'($urandom_range(0, 3));
        repeat (d) @(posedge clk);
        #1;
        core_done = 1'b1; core_data_out = v; core_nof = n;
        m_res.push_back({(m_issue_mode == 2'b00) ? 2'b00 : n, v});
        exp_done_q.push_back(32'(cyc + 1));
        m_pending = 0;
        @(posedge clk); #1;
        core_done = 1'b0; core_data_out = $urandom; core_nof = '0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (core_start) begin
        if (exp_start_q.size() == 0) check("unexpected_core_start", 1, 0);
        else begin
          logic [99:0] e;
          e = exp_start_q.pop_front();
          check("start_cycle", 64'(cyc), 64'(e[99:68]));
          check("start_mode", core_mode, e[67:66]);
          check("start_data_in", core_data_in, e[65:34]);
          check("start_noise", core_noise, e[33:2]);
          check("start_cw", core_cw_width, e[1:0]);
        end
      end
      if (operation_done) begin
        last_done_cyc = cyc;
        if (exp_done_q.size() == 0) check("unexpected_operation_done", 1, 0);
        else check("op_done_cycle", 64'(cyc), 64'(exp_done_q.pop_front()));
      end
      if (bus.PSEL && bus.PENABLE && bus.PREADY && !bus.PWRITE) begin
        if (exp_rd_q.size() == 0) check("unexpected_read", 1, 0);
        else check(rd_name_q.pop_front(), bus.PRDATA, exp_rd_q.pop_front());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, "_core_start"}, core_start, 0);
    check({tag, "_core_regs"}, {core_mode, core_data_in, core_noise, core_cw_width}, 0);
    check({tag, "_op_done_irq"}, {operation_done, irq}, 0);
    check({tag, "_apb_out"}, {bus.PREADY, bus.PRDATA}, 0);
    check({tag, "_fsm"}, fsm_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d, w, s;
    logic [31:0] old_noise;
    bus.PADDR = '0; bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PWDATA = '0;
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) apb_read(3'(i), 32'h0, "reset_reg");
    read_status("reset_status");
    read_result("reset_result_empty");

    // Decode: mode 01, fixed core answer after 5 cycles
    reg_write(3'd1, 32'hA5);
    reg_write(3'd3, 32'h3);
    r_fixed = 1; r_val = 32'h5A; r_nof = 2'd2;
    run_op(2'b01, 5);
    read_status("status_after_decode");
    read_result("result_decode");
    read_status("status_drained");

    // Encode stores nof 00
    reg_write(3'd1, 32'h1234);
    r_val = 32'h00C0FFEE; r_nof = 2'd3;
    run_op(2'b00, 3);
    read_status("status_encode_nof");
    read_result("result_encode");
    r_fixed = 0;

    // Register readback and unmapped offsets
    reg_write(3'd2, 32'hDEAD_BEE1);
    apb_read(3'd0, {28'd0, m_irq_en, 1'b0, m_mode}, "ctrl_readback");
    apb_read(3'd1, m_data, "data_in_readback");
    apb_read(3'd2, m_cw, "cw_readback");
    apb_read(3'd3, m_noise, "noise_readback");
    apb_write(3'd6, 32'hFFFF_FFFF);
    apb_write(3'd7, 32'hFFFF_FFFF);
    apb_read(3'd6, 32'h0, "off6_reads_zero");
    apb_read(3'd7, 32'h0, "off7_reads_zero");
    apb_read(3'd0, {28'd0, m_irq_en, 1'b0, m_mode}, "ctrl_after_unmapped");

    // NOISE write during WAIT stalls until PUSH is over; in-flight noise kept
    old_noise = m_noise;
    r_delay = 8;
    ctrl_write(2'b10, 1'b1, 1'b0, d);
    apb_xfer(3'd3, 1'b1, 32'h0000_7777, d, w);
    check("noise_stall_release_cycle", 64'(d), 64'(last_done_cyc + 2));
    check("noise_stall_had_waits", (w > 0), 1);
    @(negedge clk);
    check("core_noise_unchanged", core_noise, old_noise[DW-1:0]);
    m_noise = 32'h0000_7777;
    wait_idle();
    read_result("result_after_stall");

    // Fill the queue, then a rejected start
    for (int i = 0; i < DEPTH; i++) begin
      reg_write(3'd1, $urandom);
      run_op(2'($urandom_range(0, 3)), 0);
    end
    read_status("status_full");
    ctrl_write(2'b11, 1'b1, 1'b0, d);
    repeat (6) @(posedge clk);
    read_status("status_rej");
    apb_read(3'd0, {28'd0, m_irq_en, 1'b0, m_mode}, "ctrl_written_on_rej");
    reg_write(3'd4, 32'h8);
    read_status("status_rej_cleared");
    ctrl_write(2'b01, 1'b0, 1'b1, d);
    repeat (2) @(posedge clk);
    check_irq("irq_queue_nonempty");
    for (int i = 0; i < DEPTH; i++) read_result("drain_result");
    read_result("pop_when_empty");
    read_status("status_after_drain");
    repeat (2) @(posedge clk);
    check_irq("irq_low_when_clear");

    // Push and pop completing on the same edge
    r_delay = 3;
    ctrl_write(2'b01, 1'b1, 1'b0, d);
    wait_idle();
    r_delay = 4;
    ctrl_write(2'b01, 1'b1, 1'b0, s);
    repeat (2) @(posedge clk);
    read_result("pop_during_push");
    wait_idle();
    read_status("status_push_pop_same_edge");
    read_result("result_after_push_pop");

    // Core done outside WAIT is ignored
    @(posedge clk); #1 core_done = 1'b1; core_data_out = 32'hBAD; core_nof = 2'd1;
    @(posedge clk); #1 core_done = 1'b0;
    repeat (3) @(posedge clk);
    read_status("status_spurious_done");

    // Watchdog timeout with irq enabled
    r_silent = 1;
    ctrl_write(2'b01, 1'b1, 1'b1, s);
    while (cyc < s + TMO + 1) @(negedge clk);
    check("irq_before_timeout", irq, 0);
    @(negedge clk);
    check("irq_after_timeout", irq, 1);
    m_tmo = 1; m_pending = 0;
    check("fsm_idle_after_timeout", fsm_state, 0);
    read_status("status_tmo");
    reg_write(3'd4, 32'h10);
    read_status("status_tmo_cleared");

    // Reset while waiting on the core
    ctrl_write(2'b01, 1'b1, 1'b1, s);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    check_all_zero("mid_reset");
    exp_start_q.delete();
    model_reset();
    r_silent = 0;
    @(posedge clk); #1 rst = 1'b1;
    read_status("status_after_mid_reset");

    // Random operations with interleaved reads
    for (int k = 0; k < 14; k++) begin
      reg_write(3'd1, $urandom);
      if ($urandom_range(0, 1)) reg_write(3'd3, $urandom);
      if ($urandom_range(0, 2) == 0) reg_write(3'd2, $urandom);
      m_irq_en = 1'($urandom_range(0, 1));
      run_op(2'($urandom_range(0, 3)), 0);
      check_irq("irq_random");
      if (m_res.size() == DEPTH || $urandom_range(0, 2) == 0) read_result("result_random");
      if ($urandom_range(0, 1)) read_status("status_random");
    end
    while (m_res.size() > 0) read_result("result_final_drain");
    read_status("status_final");

    repeat (4) @(posedge clk);
    check("start_queue_drained", exp_start_q.size(), 0);
    check("done_queue_drained", exp_done_q.size(), 0);
    check("read_queue_drained", exp_rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
